btn_debounce: RTL and testbench
===============================

Name: btn_debounce

Overview:
- Per-button input conditioner. Sits directly upstream of the LED toggle logic.
- Synchronises one raw push-button input to sysclk and filters contact bounce with a counter-based FSM.
- Emits a debounced level plus single-cycle press, release and long-press pulses.
- The downstream toggle stage consumes press_pulse directly, with no further edge detection. Instantiate once per button.

Parameters:
- DEBOUNCE_CYCLES, 120000, consecutive stable samples that confirm a transition (10 ms at 12 MHz); legal range >= 2.
- HOLD_CYCLES, 6000000, cycles spent in PRESSED before hold_pulse fires (0.5 s at 12 MHz); must be > DEBOUNCE_CYCLES.

Ports:
- sysclk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous, active-low reset.
- btn_raw  input  1  asynchronous raw button, 1 = pressed.
- btn_level  output  1  debounced button state.
- press_pulse  output  1  one-cycle pulse per confirmed press.
- release_pulse  output  1  one-cycle pulse per confirmed release.
- hold_pulse  output  1  one-cycle pulse, at most once per press, after a long hold.

Behaviour:
- One clock; reset is synchronous and active-low. When rst_n is sampled 0 at a sysclk edge, all registers clear:
  - sync flops s1 = s2 = 0
  - state = IDLE, deb_cnt = 0, hold_cnt = 0, hold_done = 0
  - btn_level = press_pulse = release_pulse = hold_pulse = 0
- Synchroniser: s1 <= btn_raw, s2 <= s1. The FSM samples only s2; btn_raw is never used elsewhere.
- Counter widths: deb_cnt is $clog2(DEBOUNCE_CYCLES) bits; hold_cnt is $clog2(HOLD_CYCLES) bits. Neither counter wraps.
- States and transitions (all outputs registered; pulses are 0 unless stated):
  - IDLE: if s2 = 1, go to DEB_HI and set deb_cnt = 0.
  - DEB_HI:
    - If s2 = 0, return to IDLE. No pulse.
    - Else if deb_cnt = DEBOUNCE_CYCLES-1, go to PRESSED; press_pulse = 1; hold_cnt = 0; hold_done = 0.
    - Else deb_cnt + 1.
  - PRESSED:
    - hold_cnt increments and saturates at HOLD_CYCLES-1.
    - When hold_cnt = HOLD_CYCLES-1 and hold_done = 0: hold_pulse = 1, hold_done = 1.
    - If s2 = 0, go to DEB_LO and set deb_cnt = 0.
  - DEB_LO:
    - If s2 = 1, return to PRESSED. No pulse. hold_cnt and hold_done are kept; hold_cnt does not count while in DEB_LO.
    - Else if deb_cnt = DEBOUNCE_CYCLES-1, go to IDLE; release_pulse = 1.
    - Else deb_cnt + 1.
- btn_level = 1 exactly when the registered state is PRESSED or DEB_LO.
- Latency: let edge 0 be the first sysclk edge that samples btn_raw = 1, with btn_raw held high afterwards.
  - s2 = 1 after edge 1; DEB_HI entered at edge 2.
  - press_pulse and btn_level rise at edge DEBOUNCE_CYCLES+2. press_pulse falls one edge later.
  - Release is symmetric: release_pulse rises and btn_level falls at edge DEBOUNCE_CYCLES+2 after the first edge sampling 0.
- hold_pulse fires at edge HOLD_CYCLES-1 after entry into PRESSED, counting only edges spent in PRESSED.
- At most one of press_pulse, release_pulse and hold_pulse is high in any cycle; press and hold are structurally exclusive.
- Bounce shorter than DEBOUNCE_CYCLES+1 samples produces no pulse and no btn_level change.
- Button held through reset: after rst_n rises, the press is treated as new and press_pulse fires after the normal debounce latency.
- Reset mid-debounce or mid-hold: aborts immediately. No pulse is emitted in the reset cycle or after it.
- DEBOUNCE_CYCLES = 2 is legal; the FSM must not skip states.

Test Plan:
- DEBOUNCE_CYCLES=4, HOLD_CYCLES=20; btn_raw rises at edge 0 and stays high -> press_pulse=1 and btn_level=1 after edge 6 only; press_pulse=0 after edge 7.
- Same params; btn_raw 1-0-1-0 glitches of 1–4 cycles each, then 0 -> no pulse ever, btn_level stays 0.
- Press held 40 cycles after press_pulse -> exactly one hold_pulse, 19 cycles after press_pulse; no second hold_pulse.
- Release with a 3-cycle high bounce inside DEB_LO -> no release_pulse and no second press_pulse. Then stable 0 -> release_pulse and btn_level=0 at edge 6 after the last 0-sampling restart.
- rst_n=0 for 1 cycle while in DEB_HI with deb_cnt=3 -> all outputs 0, state IDLE; btn still high -> press_pulse 7 edges after reset release.
- Random btn_raw stream (10k cycles) against a reference model -> pulses never overlap; press_pulse and release_pulse strictly alternate, starting with press.

Source files
------------

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser plus counter FSM that debounces one
// push button and emits level, press, release and long-hold pulses.
//
// Ports:
//   sysclk        system clock, all logic on posedge
//   rst_n         synchronous active-low reset
//   btn_raw       asynchronous raw button, 1 = pressed
//   btn_level     debounced button state
//   press_pulse   one-cycle pulse per confirmed press
//   release_pulse one-cycle pulse per confirmed release
//   hold_pulse    one-cycle pulse, once per press, after a long hold
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int HOLD_CYCLES     = 6000000
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES);

  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DEB_HI  = 2'd1,
    PRESSED = 2'd2,
    DEB_LO  = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic s1;
  logic s2;

  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] deb_nx;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_nx;
  logic          hold_done;
  logic          done_nx;

  logic level_nx;
  logic press_nx;
  logic rel_nx;
  logic hold_p_nx;

  // Two-flop synchroniser; only s2 feeds the FSM.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // State register plus registered counters and outputs.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state         <= IDLE;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      hold_done     <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      hold_pulse    <= 1'b0;
    end else begin
      state         <= state_nx;
      deb_cnt       <= deb_nx;
      hold_cnt      <= hold_nx;
      hold_done     <= done_nx;
      btn_level     <= level_nx;
      press_pulse   <= press_nx;
      release_pulse <= rel_nx;
      hold_pulse    <= hold_p_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (s2) state_nx = DEB_HI;
      end
      DEB_HI: begin
        if (!s2)
          state_nx = IDLE;
        else if (deb_cnt == DEB_MAX)
          state_nx = PRESSED;
      end
      PRESSED: begin
        if (!s2) state_nx = DEB_LO;
      end
      DEB_LO: begin
        if (s2)
          state_nx = PRESSED;
        else if (deb_cnt == DEB_MAX)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Counter and output logic.
  always_comb begin
    deb_nx    = deb_cnt;
    hold_nx   = hold_cnt;
    done_nx   = hold_done;
    press_nx  = 1'b0;
    rel_nx    = 1'b0;
    hold_p_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (s2) deb_nx = '0;
      end
      DEB_HI: begin
        if (s2) begin
          if (deb_cnt == DEB_MAX) begin
            press_nx = 1'b1;
            hold_nx  = '0;
            done_nx  = 1'b0;
          end else begin
            deb_nx = deb_cnt + 1'b1;
          end
        end
      end
      PRESSED: begin
        if (hold_cnt != HOLD_MAX)
          hold_nx = hold_cnt + 1'b1;
        // Fire on the edge the counter reaches its limit, once per press.
        if (hold_nx == HOLD_MAX && !hold_done) begin
          hold_p_nx = 1'b1;
          done_nx   = 1'b1;
        end
        if (!s2) deb_nx = '0;
      end
      DEB_LO: begin
        if (!s2) begin
          if (deb_cnt == DEB_MAX)
            rel_nx = 1'b1;
          else
            deb_nx = deb_cnt + 1'b1;
        end
      end
      default: begin
        deb_nx = '0;
      end
    endcase
  end

  assign level_nx = (state_nx == PRESSED) || (state_nx == DEB_LO);

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed and random stimulus for btn_debounce, checked
// every cycle against a run-length reference model.
module tb_btn_debounce;

  localparam int D = 4;
  localparam int H = 20;

  logic sysclk;
  logic rst_n;
  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic hold_pulse;

  int total;
  int bad;

  // Reference model: raw delay line, debounced level, count of
  // consecutive samples disagreeing with the level, hold progress.
  logic dl0, dl1;
  logic m_level;
  int   m_run;
  int   m_hcnt;
  logic m_hdone;
  logic m_p, m_r, m_h;

  int last_pr;
  int np, nr, nh;

  btn_debounce #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H)
  ) dut (
    .sysclk(sysclk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .hold_pulse(hold_pulse)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic n);
    logic samp;
    m_p = 0;
    m_r = 0;
    m_h = 0;
    if (!n) begin
      dl0 = 0;
      dl1 = 0;
      m_level = 0;
      m_run = 0;
      m_hcnt = 0;
      m_hdone = 0;
    end else begin
      samp = dl1;
      dl1 = dl0;
      dl0 = r;
      // Settled high: counts towards the long hold.
      if (m_level && m_run == 0) begin
        if (m_hcnt < H - 1) m_hcnt++;
        if (m_hcnt == H - 1 && !m_hdone) begin
          m_h = 1;
          m_hdone = 1;
        end
      end
      if (samp != m_level) begin
        m_run++;
        if (m_run == D + 1) begin
          m_level = !m_level;
          m_run = 0;
          if (m_level) begin
            m_p = 1;
            m_hcnt = 0;
            m_hdone = 0;
          end else begin
            m_r = 1;
          end
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic n);
    @(negedge sysclk);
    btn_raw = r;
    rst_n = n;
    @(posedge sysclk);
    model(r, n);
    #1;
    chk("level", btn_level, m_level);
    chk("press", press_pulse, m_p);
    chk("release", release_pulse, m_r);
    chk("hold", hold_pulse, m_h);
    chk("overlap", (press_pulse + release_pulse + hold_pulse) <= 1, 1);
    if (!n) last_pr = 0;
    if (press_pulse) begin
      chk("alt_p", last_pr == 1, 0);
      last_pr = 1;
      np++;
    end
    if (release_pulse) begin
      chk("alt_r", last_pr, 1);
      last_pr = 2;
      nr++;
    end
    if (hold_pulse) nh++;
  endtask

  initial begin
    int pe, he, re, k0;
    logic pat [];
    total = 0;
    bad = 0;
    last_pr = 0;
    np = 0;
    nr = 0;
    nh = 0;
    sysclk = 0;
    btn_raw = 0;
    rst_n = 0;
    dl0 = 0;
    dl1 = 0;
    m_level = 0;
    m_run = 0;
    m_hcnt = 0;
    m_hdone = 0;

    step(0, 0);
    step(0, 0);
    chk("rst_out", {btn_level, press_pulse, release_pulse, hold_pulse}, 0);
    step(0, 1);
    step(0, 1);

    // Press latency and single long-hold pulse.
    pe = -1;
    he = -1;
    nh = 0;
    for (int k = 0; k < 50; k++) begin
      step(1, 1);
      if (press_pulse && pe < 0) pe = k;
      if (hold_pulse && he < 0) he = k;
    end
    chk("press_at", pe, 6);
    chk("hold_dly", he - pe, 19);
    chk("hold_cnt", nh, 1);

    // Release with a 3-cycle high bounce.
    pat = new[16];
    foreach (pat[i]) pat[i] = 0;
    pat[2] = 1;
    pat[3] = 1;
    pat[4] = 1;
    re = -1;
    np = 0;
    foreach (pat[i]) begin
      step(pat[i], 1);
      if (release_pulse && re < 0) re = i;
    end
    chk("rel_at", re, 11);
    chk("rel_nopress", np, 0);
    chk("rel_level", btn_level, 0);
    for (int k = 0; k < 4; k++) step(0, 1);

    // Reset while debouncing high with deb_cnt = 3.
    np = 0;
    for (int k = 0; k < 6; k++) step(1, 1);
    step(1, 0);
    chk("mid_rst", {btn_level, press_pulse, release_pulse, hold_pulse}, 0);
    pe = -1;
    for (int k = 1; k <= 10; k++) begin
      step(1, 1);
      if (press_pulse && pe < 0) pe = k;
    end
    chk("rst_press", pe, 7);
    for (int k = 0; k < 12; k++) step(0, 1);

    // Glitches of 1-4 cycles never confirm.
    np = 0;
    nr = 0;
    for (int len = 1; len <= 4; len++) begin
      for (int k = 0; k < len; k++) step(1, 1);
      for (int k = 0; k < len; k++) step(0, 1);
    end
    for (int k = 0; k < 10; k++) step(0, 1);
    chk("glitch_p", np, 0);
    chk("glitch_r", nr, 0);
    chk("glitch_lvl", btn_level, 0);

    // Random bursty stream with occasional resets.
    k0 = 0;
    while (k0 < 10000) begin
      logic lv;
      int len;
      lv = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        len = $urandom_range(5, 40);
      else
        len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        step(lv, ($urandom_range(0, 299) != 0));
        k0++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
